trax_move_tx: RTL and testbench

Serializes one 22-bit Trax move word into the ASCII Trax move notation and sends it as 8N1 UART characters on `tx`. It is the sending end of the move link whose receiving end delivers decoded move words to the game core. The core loads a chosen move, pulses `start`, and waits for `done`. Column, row and tile are encoded as text, for example `C12/` followed by a line terminator.

---
 rtl/trax_move_tx.sv | 191 +++++++++++++++++++
 tb/tb_trax_move_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trax_move_tx.sv
// Serializes a 22-bit Trax move {tile, col, row} as ASCII text over an 8N1 UART line.
// Define TRAX_TX_CRLF_EN to end each move with CR LF instead of LF alone.
module trax_move_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [21:0] move,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        tx
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StConv, StLoad, StStart, StData, StStop, StFin} state_e;

  state_e          state_q, state_d;
  logic [4:0]      conv_q, conv_d;
  logic [9:0]      rem_q, rem_d;
  logic [3:0]      hund_q, hund_d;
  logic [3:0]      tens_q, tens_d;
  logic [4:0]      col_q, col_d;
  logic [1:0]      tile_q, tile_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      bit_q, bit_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic            err_q, err_d;

  logic       move_valid;
  logic [7:0] char_buf [8];
  logic [2:0] buf_len;
  logic [2:0] pos;
  logic [7:0] tile_char;

  assign move_valid = (move[21:20] != 2'b00) && (move[19:10] <= 10'd26) && (move[9:0] <= 10'd999);

  // Character buffer derived from the latched move and the decimal split.
  always_comb begin
    for (int i = 0; i < 8; i++) char_buf[i] = 8'h00;
    unique case (tile_q)
      2'b01:   tile_char = 8'h2B;
      2'b10:   tile_char = 8'h2F;
      default: tile_char = 8'h5C;
    endcase
    pos = 3'd0;
    char_buf[pos] = 8'h40 + {3'b000, col_q};
    pos = pos + 3'd1;
    if (hund_q != 4'd0) begin
      char_buf[pos] = {4'h3, hund_q};
      pos = pos + 3'd1;
    end
    if ((hund_q != 4'd0) || (tens_q != 4'd0)) begin
      char_buf[pos] = {4'h3, tens_q};
      pos = pos + 3'd1;
    end
    char_buf[pos] = {4'h3, rem_q[3:0]};
    pos = pos + 3'd1;
    char_buf[pos] = tile_char;
    pos = pos + 3'd1;
`ifdef TRAX_TX_CRLF_EN
    char_buf[pos] = 8'h0D;
    pos = pos + 3'd1;
`endif
    char_buf[pos] = 8'h0A;
    pos = pos + 3'd1;
    buf_len = pos;
  end

  always_comb begin
    state_d = state_q;
    conv_d  = conv_q;
    rem_d   = rem_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    col_d   = col_q;
    tile_d  = tile_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (move_valid) begin
            tile_d  = move[21:20];
            col_d   = move[14:10];
            rem_d   = move[9:0];
            hund_d  = 4'd0;
            tens_d  = 4'd0;
            conv_d  = 5'd0;
            idx_d   = 3'd0;
            state_d = StConv;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StConv: begin
        // First nine slots peel hundreds, next nine peel tens.
        if (conv_q < 5'd9) begin
          if (rem_q >= 10'd100) begin
            rem_d  = rem_q - 10'd100;
            hund_d = hund_q + 4'd1;
          end
        end else if (rem_q >= 10'd10) begin
          rem_d  = rem_q - 10'd10;
          tens_d = tens_q + 4'd1;
        end
        conv_d = conv_q + 5'd1;
        if (conv_q == 5'd17) state_d = StLoad;
      end
      StLoad: begin
        shreg_d = char_buf[idx_q];
        idx_d   = idx_q + 3'd1;
        baud_d  = '0;
        state_d = StStart;
      end
      StStart: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          state_d = (idx_q == buf_len) ? StFin : StLoad;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      conv_q  <= '0;
      rem_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      col_q   <= '0;
      tile_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      conv_q  <= conv_d;
      rem_q   <= rem_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      col_q   <= col_d;
      tile_q  <= tile_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      err_q   <= err_d;
    end
  end

  assign tx   = (state_q == StStart) ? 1'b0 : (state_q == StData) ? shreg_q[0] : 1'b1;
  assign busy = (state_q != StIdle) && (state_q != StFin);
  assign done = (state_q == StFin);
  assign err  = err_q;

endmodule

// File: tb/tb_trax_move_tx.sv
// Self-checking bench for trax_move_tx: cycle-level reference model plus a UART byte capture.
module tb_trax_move_tx;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [21:0] move = '0;
  logic        busy, done, err, tx;

  trax_move_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .move (move),
    .busy (busy),
    .done (done),
    .err  (err),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state: expected {tx, busy, done} per cycle, err separately.
  logic [2:0] exp_q[$];
  logic [2:0] exp_now = 3'b100;
  logic       exp_err = 1'b0;
  logic       new_err;
  bit         model_on = 0;
  bit         cur_active = 0;
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;

  function automatic logic [21:0] mv(input int tile, input int col, input int row);
    return {tile[1:0], col[9:0], row[9:0]};
  endfunction

  function automatic bit is_valid(input logic [21:0] m);
    return (m[21:20] != 2'b00) && (int'(m[19:10]) <= 26) && (int'(m[9:0]) <= 999);
  endfunction

  function automatic void push_frame(input logic [21:0] m);
    logic [7:0] ch[$];
    int row, col;
    row = int'(m[9:0]);
    col = int'(m[19:10]);
    ch.push_back(8'(8'h40 + col));
    if (row >= 100) ch.push_back(8'(48 + row / 100));
    if (row >= 10) ch.push_back(8'(48 + (row / 10) % 10));
    ch.push_back(8'(48 + row % 10));
    case (m[21:20])
      2'b01:   ch.push_back(8'h2B);
      2'b10:   ch.push_back(8'h2F);
      default: ch.push_back(8'h5C);
    endcase
`ifdef TRAX_TX_CRLF_EN
    ch.push_back(8'h0D);
`endif
    ch.push_back(8'h0A);
    repeat (19) exp_q.push_back(3'b110);
    foreach (ch[j]) begin
      repeat (CPB) exp_q.push_back(3'b010);
      for (int b = 0; b < 8; b++) repeat (CPB) exp_q.push_back({ch[j][b], 2'b10});
      repeat (CPB) exp_q.push_back(3'b110);
      if (j != ch.size() - 1) exp_q.push_back(3'b110);
    end
    exp_q.push_back(3'b101);
  endfunction

  initial forever begin
    @(posedge clk);
    model_on = 1;
    if (reset) begin
      exp_q.delete();
      exp_now    = 3'b100;
      exp_err    = 1'b0;
      cur_active = 0;
    end else begin
      new_err = 1'b0;
      if (!cur_active && start) begin
        if (is_valid(move)) push_frame(move);
        else new_err = 1'b1;
      end
      if (exp_q.size() > 0) begin
        exp_now    = exp_q.pop_front();
        cur_active = 1;
      end else begin
        exp_now    = 3'b100;
        cur_active = 0;
      end
      exp_err = new_err;
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      checks++;
      if ({tx, busy, done, err} !== {exp_now, exp_err}) begin
        errors++;
        $display("FAIL cycle %0d tx/busy/done/err: got %b, required %b", cyc,
                 {tx, busy, done, err}, {exp_now, exp_err});
      end
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
    end
  end

  // UART capture: sample each bit one cycle into its period.
  initial forever begin
    @(negedge clk);
    if (model_on && tx === 1'b0) begin
      repeat (CPB + 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        rx_byte[i] = tx;
        if (i < 7) repeat (CPB) @(negedge clk);
      end
      repeat (CPB) @(negedge clk);
      rx_q.push_back(rx_byte);
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic pulse_start(input logic [21:0] m, output int t);
    @(posedge clk);
    #1;
    move  = m;
    start = 1'b1;
    t     = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    move  = 22'($urandom);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got timeout, required done pulse");
    end
    @(negedge clk);
  endtask

  task automatic check_bytes(input logic [63:0] bytes, input int n);
    logic [7:0] exp[$];
    for (int i = 0; i < n; i++) exp.push_back(bytes[8*(n-1-i) +: 8]);
`ifdef TRAX_TX_CRLF_EN
    exp.insert(exp.size() - 1, 8'h0D);
`endif
    check("byte count", rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      check($sformatf("byte %0d", i), int'(rx_q[i]), int'(exp[i]));
  endtask

  task automatic send_check(input logic [21:0] m, input logic [63:0] bytes, input int n);
    int t, d0, fall;
    rx_q.delete();
    d0 = done_cnt;
    pulse_start(m, t);
    fall = -1;
    for (int i = 0; i < 200 && fall < 0; i++) begin
      @(negedge clk);
      if (tx === 1'b0) fall = cyc;
    end
    check("first start bit latency", fall - t, 20);
    wait_done();
    check("done pulses", done_cnt - d0, 1);
    check("busy after done", int'(busy), 0);
    check_bytes(bytes, n);
  endtask

  initial begin
    int t, t2, e0, d0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset tx", int'(tx), 1);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset err", int'(err), 0);

    send_check(mv(1, 0, 0), 64'h40302B0A, 4);
    send_check(mv(2, 3, 12), 64'h4331322F0A, 5);
    send_check(mv(3, 26, 305), 64'h5A3330355C0A, 6);
    send_check(mv(2, 5, 100), 64'h453130302F0A, 6);
    send_check(mv(1, 1, 7), 64'h41372B0A, 4);

    // Invalid moves: tile 00, col 27, row 1000.
    e0 = err_cnt;
    pulse_start(mv(0, 1, 1), t);
    repeat (2) @(negedge clk);
    pulse_start(mv(1, 27, 1), t);
    repeat (2) @(negedge clk);
    pulse_start(mv(1, 1, 1000), t);
    repeat (3) @(negedge clk);
    check("err pulses", err_cnt - e0, 3);
    check("busy after invalid", int'(busy), 0);
    check("tx after invalid", int'(tx), 1);

    // Second start during byte 2 is ignored.
    rx_q.delete();
    d0 = done_cnt;
    pulse_start(mv(1, 5, 7), t);
    while (cyc < t + 20 + 41 + 10) @(posedge clk);
    pulse_start(mv(2, 9, 9), t2);
    wait_done();
    repeat (100) @(negedge clk);
    check("done pulses with ignored start", done_cnt - d0, 1);
    check_bytes(64'h45372B0A, 4);

    // Reset in the middle of data bit 0 of the first character.
    pulse_start(mv(2, 3, 12), t);
    while (cyc < t + 25) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("tx after mid-frame reset", int'(tx), 1);
    check("busy after mid-frame reset", int'(busy), 0);
    repeat (60) @(negedge clk);
    send_check(mv(3, 26, 999), 64'h5A3939395C0A, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
